// File: rtl/parallel_adder_8bit.sv
// Registered 8-bit ripple-carry adder with a one-cycle valid pipeline.
// Optional signed-overflow output ovf is enabled by defining PARALLEL_ADDER_OVF_EN.
module parallel_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef PARALLEL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  // The carry chain is built in one process so each stage sees the previous carry in order.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = in1[i] ^ in2[i] ^ c[i];
      c[i+1] = (in1[i] & in2[i]) | (c[i] & (in1[i] ^ in2[i]));
    end
  end

  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef PARALLEL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_parallel_adder_8bit.sv
// Scoreboard bench for parallel_adder_8bit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is due.
module tb_parallel_adder_8bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in1 = '0;
  logic [7:0] in2 = '0;
  logic       cin = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       out_valid;
`ifdef PARALLEL_ADDER_OVF_EN
  logic       ovf;
`endif

  parallel_adder_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .out_valid(out_valid)
`ifdef PARALLEL_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
    int res;
    bit ov;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_res = 0;
  bit   last_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input int a, input int b, input int c);
    exp_t e;
    int sa, sb, ss;
    e.a   = a;
    e.b   = b;
    e.c   = c;
    e.res = (a + b + c) % 512;
    sa    = (a >= 128) ? a - 256 : a;
    sb    = (b >= 128) ? b - 256 : b;
    ss    = sa + sb + c;
    e.ov  = (ss > 127) || (ss < -128);
    e.due = 0;
    return e;
  endfunction

  task automatic drive(input int a, input int b, input int c, input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    in1      = a[7:0];
    in2      = b[7:0];
    cin      = c[0];
    in_valid = v;
    if (v && rst_n) begin
      e     = model(a, b, c);
      e.due = cyc + 1;
      q.push_back(e);
    end
  endtask

  // Monitor: compares at every falling edge, away from the capturing edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("out_valid_due", int'(out_valid), 1);
      check("result", int'({cout, sum}), e.res);
`ifdef PARALLEL_ADDER_OVF_EN
      check("ovf", int'(ovf), int'(e.ov));
`endif
      $display("txn %0d+%0d+%0d -> sum=%0d cout=%0b (req sum=%0d cout=%0b)",
               e.a, e.b, e.c, sum, cout, e.res % 256, e.res / 256);
      last_res = e.res;
      last_ov  = e.ov;
    end else begin
      check("out_valid_idle", int'(out_valid), 0);
      check("hold", int'({cout, sum}), last_res);
`ifdef PARALLEL_ADDER_OVF_EN
      check("ovf_hold", int'(ovf), int'(last_ov));
`endif
    end
  end

  initial begin
    #3;
    check("rst_sum", int'(sum), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Sequence scenario
    for (int i = 0; i < 6; i++) drive(10 + i, 5 + i, i % 2, 1'b1);

    // Wrap and boundary values
    drive(255, 255, 1, 1'b1);
    drive(128, 128, 0, 1'b1);
    drive(0, 0, 0, 1'b1);
    drive(255, 0, 1, 1'b1);
    drive(127, 1, 0, 1'b1);

    // Hold with changing operands
    drive(200, 100, 1, 1'b1);
    for (int i = 0; i < 4; i++) drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1), 1'b0);

    // Reset mid-stream: one operation in flight gets discarded
    drive(20, 30, 1, 1'b1);
    #2;
    rst_n = 1'b0;
    q.delete();
    last_res = 0;
    last_ov  = 1'b0;
    #1;
    check("async_rst_sum", int'(sum), 0);
    check("async_rst_cout", int'(cout), 0);
    check("async_rst_out_valid", int'(out_valid), 0);
`ifdef PARALLEL_ADDER_OVF_EN
    check("async_rst_ovf", int'(ovf), 0);
`endif
    drive(1, 2, 0, 1'b1);
    drive(3, 4, 1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    begin
      exp_t e;
      in1      = 8'd40;
      in2      = 8'd50;
      cin      = 1'b1;
      in_valid = 1'b1;
      e        = model(40, 50, 1);
      e.due    = cyc + 1;
      q.push_back(e);
    end

    // Randomized back-to-back traffic with occasional bubbles
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
            ($urandom_range(0, 7) != 0));
    end

    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1'b0);
    @(posedge clk);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parallel_adder_8bit.md
PARALLEL_ADDER_8BIT -- requirements
Module: parallel_adder_8bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and sum width; 8 is the only qualified value.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in1, input, 8 bits: operand A, unsigned.
REQ-006 Port in2, input, 8 bits: operand B, unsigned.
REQ-007 Port cin, input, 1 bit: carry-in.
REQ-008 Port in_valid, input, 1 bit: operands valid this cycle.
REQ-009 Port sum, output, 8 bits: registered sum, in1+in2+cin modulo 256.
REQ-010 Port cout, output, 1 bit: registered carry-out of bit 7.
REQ-011 Port out_valid, output, 1 bit: sum and cout hold a new result.

Function
REQ-012 The adder SHALL be a parallel (ripple) structure of 8 full-adder stages: stage i gives s[i]=a^b^c and c[i+1]=ab|c(a^b), with c[0]=cin.
REQ-013 The combinational result SHALL be the 9-bit value {c[8],s[7:0]} = in1+in2+cin.
REQ-014 On a rising clk edge with in_valid=1, sum and cout SHALL load the result and out_valid SHALL go to 1; latency is exactly 1 cycle.
REQ-015 On a rising clk edge with in_valid=0, sum and cout SHALL hold their values and out_valid SHALL go to 0.
REQ-016 Back-to-back valid inputs SHALL produce one result per cycle with no stall; there is no backpressure.
REQ-017 Wrap-around: results of 256 or more SHALL set cout=1, and sum SHALL hold the low 8 bits.
REQ-018 Boundaries: 255+255+1 SHALL give sum=255, cout=1; 0+0+0 SHALL give sum=0, cout=0; 255+0+1 SHALL give sum=0, cout=1.

Reset
REQ-019 When rst_n=0, sum, cout and out_valid SHALL go to 0 immediately, independent of clk.
REQ-020 While rst_n=0, inputs SHALL be ignored.
REQ-021 An operation in flight when reset asserts SHALL be discarded.
REQ-022 The first valid capture SHALL occur on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 With macro PARALLEL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit).
REQ-024 ovf SHALL be registered like sum and SHALL equal c[8]^c[7], the two's-complement signed overflow; it resets to 0.
REQ-025 Without PARALLEL_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-026 Scenario sequence: in1=10, in2=5, cin=0 then 11/6/1, 12/7/0, 13/8/1, 14/9/0, 15/10/1, each held with in_valid=1. Required results one cycle after each: sum=15, 18, 19, 22, 23, 26, with cout=0 and out_valid=1.
REQ-027 Scenario wrap: in1=255, in2=255, cin=1 -> sum=255, cout=1; then in1=128, in2=128, cin=0 -> sum=0, cout=1, and with the macro, ovf=1.
REQ-028 Scenario hold: present a valid result, then drive in_valid=0 with changing operands -> sum and cout unchanged, out_valid=0.
REQ-029 Scenario reset: assert rst_n=0 mid-stream, between clock edges -> sum=0, cout=0, out_valid=0 immediately; after release, the first valid input gives a result one cycle later.
REQ-030 Scenario exhaustive: random or exhaustive in1, in2, cin with in_valid=1 -> {cout,sum} equals in1+in2+cin on every following cycle.
